// File: rtl/mru_list_streamer_if.sv
// Beat channel from mru_list_streamer to its consumer: one list entry per
// valid/ready handshake.
interface mru_list_streamer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] m_data_out;
    logic [1:0]        m_index_out;
    logic              m_last_out;
    logic              m_valid_out;
    logic              m_ready_in;

    modport master (
        output m_data_out,
        output m_index_out,
        output m_last_out,
        output m_valid_out,
        input  m_ready_in
    );

    modport slave (
        input  m_data_out,
        input  m_index_out,
        input  m_last_out,
        input  m_valid_out,
        output m_ready_in
    );
endinterface

// File: rtl/mru_list_streamer.sv
// Watches a 4-entry MRU list and streams every changed list as one frame of
// its leading valid entries, newest first. Changes that land mid-frame merge.
module mru_list_streamer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic [DATA_W-1:0]     in_0,
    input  logic [DATA_W-1:0]     in_1,
    input  logic [DATA_W-1:0]     in_2,
    input  logic [DATA_W-1:0]     in_3,
    input  logic                  in_valid_0,
    input  logic                  in_valid_1,
    input  logic                  in_valid_2,
    input  logic                  in_valid_3,
    input  logic                  enable_in,
    mru_list_streamer_if.master   m,
    output logic                  busy_out,
    output logic [CNT_W-1:0]      overrun_cnt_out
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cur_d    [4];
    logic [3:0]        cur_v;
    logic [DATA_W-1:0] shadow_d [4];
    logic [3:0]        shadow_v;
    logic [DATA_W-1:0] snap_d   [4];
    logic [2:0]        len_now, len_q;
    logic [1:0]        idx_q;
    logic              pending_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              change_det, handshake, is_last, start;

    assign cur_d[0] = in_0;
    assign cur_d[1] = in_1;
    assign cur_d[2] = in_2;
    assign cur_d[3] = in_3;
    assign cur_v    = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

    // Data of an invalid slot is don't-care, so it never counts as a change.
    always_comb begin
        change_det = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((cur_v[i] != shadow_v[i]) ||
                (cur_v[i] && shadow_v[i] && (cur_d[i] != shadow_d[i])))
                change_det = 1'b1;
        end
    end

    always_comb begin
        casez (cur_v)
            4'b???0: len_now = 3'd0;
            4'b??01: len_now = 3'd1;
            4'b?011: len_now = 3'd2;
            4'b0111: len_now = 3'd3;
            default: len_now = 3'd4;
        endcase
    end

    assign handshake = (state_q == SEND) && m.m_ready_in;
    assign is_last   = ({1'b0, idx_q} == (len_q - 3'd1));
    assign start     = enable_in && (pending_q || change_det) &&
                       ((state_q == IDLE) || (handshake && is_last));

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && (len_now != 3'd0)) state_d = SEND;
            SEND: if (handshake && is_last)
                      state_d = (start && (len_now != 3'd0)) ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m.m_valid_out = (state_q == SEND);
        m.m_data_out  = '0;
        m.m_index_out = '0;
        m.m_last_out  = 1'b0;
        if (state_q == SEND) begin
            m.m_data_out  = snap_d[idx_q];
            m.m_index_out = idx_q;
            m.m_last_out  = is_last;
        end
        busy_out = (state_q == SEND);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int unsigned i = 0; i < 4; i++) begin
                shadow_d[i] <= '0;
                snap_d[i]   <= '0;
            end
            shadow_v  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) shadow_d[i] <= cur_d[i];
            shadow_v <= cur_v;
            if (start) begin
                for (int unsigned i = 0; i < 4; i++) snap_d[i] <= cur_d[i];
                len_q     <= len_now;
                idx_q     <= '0;
                pending_q <= 1'b0;
            end else begin
                if (handshake && !is_last) idx_q <= idx_q + 2'd1;
                if (change_det)            pending_q <= 1'b1;
            end
            if (change_det && pending_q && !start && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign overrun_cnt_out = cnt_q;

endmodule

// File: doc/mru_list_streamer.md
# mru_list_streamer

Downstream consumer of the 4-entry most-recently-used value list (slot 0 newest, per-slot valid). Watches the list every cycle, detects any change, snapshots it, and streams the valid entries out over a valid/ready interface, one entry per beat, newest first. Changes arriving mid-frame coalesce into one follow-up frame carrying the latest list. Merged changes are counted.

## Interface
- DATA_W, 8, entry width; must match the upstream list.
- CNT_W, 8, width of the saturating overrun counter.

- clk_in  input  1  clock; all state updates on rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- in_0 .. in_3  input  DATA_W each  list entries; slot 0 is most recent.
- in_valid_0 .. in_valid_3  input  1 each  per-slot valid.
- enable_in  input  1  permits starting a new frame.
- m_data_out  output  DATA_W  streamed entry.
- m_index_out  output  2  list slot of the current beat.
- m_last_out  output  1  final beat of the frame.
- m_valid_out  output  1  beat valid.
- m_ready_in  input  1  downstream accept.
- busy_out  output  1  frame in progress (state SEND).
- overrun_cnt_out  output  CNT_W  saturating count of merged changes.

## Operation
- Shadow register holds the previous cycle's list (data and valid). It loads the inputs every cycle in every state. Reset value is all zero and all invalid.
- change_det = any slot where the valid bits differ, or both valids are 1 and the data differs. Data of invalid slots is ignored.
- Frame length len = count of consecutive set valids starting at slot 0, range 0..4. Slots after the first invalid slot are never sent.
- pending flag: set by change_det in any cycle that does not start a frame. Cleared when a frame starts.
- start = enable_in && (pending || change_det) && (state IDLE, or a last-beat handshake this cycle).
- On start: capture the current inputs into the snapshot and len; set idx = 0; clear pending.
  - If len = 0: no beats, go to or stay in IDLE.
  - Otherwise go to SEND.
- FSM:
  - IDLE: m_valid_out = 0. Go to SEND on start with len > 0.
  - SEND: m_valid_out = 1; m_data_out = snap[idx]; m_index_out = idx; m_last_out = (idx == len-1).
    - Handshake = m_valid_out && m_ready_in.
    - Handshake on a non-last beat: idx++.
    - Handshake on the last beat: start (recapture, stay in SEND at idx 0), else go to IDLE.
- overrun_cnt_out increments by 1 when change_det = 1 while pending is already 1 and no start occurs that cycle. It saturates at 2^CNT_W-1 and clears only on reset.
- enable_in low never blocks change tracking; it only delays start. Frames already in SEND always complete.
- The snapshot is independent of the inputs, so beat data cannot change while a beat waits for ready.

## Timing
- Reset (asynchronous, immediate):
  - m_valid_out 0, m_last_out 0, m_data_out 0, m_index_out 0, busy_out 0, overrun_cnt_out 0.
  - State IDLE; pending 0; shadow cleared.
- Change at the inputs in cycle N (inputs differ from shadow) with IDLE and enable_in = 1: first beat valid in cycle N+1.
- With m_ready_in held high, a frame of len L occupies L consecutive cycles.
- Back-to-back frames: if the last handshake is in cycle K and start fires, the next frame's idx 0 is valid in K+1, with no bubble.
- Beat hold: while m_valid_out = 1 and m_ready_in = 0, m_data_out, m_index_out and m_last_out are stable.
- Reset asserted mid-frame: the in-flight beat is dropped. After release, if the upstream list is non-empty, it differs from the cleared shadow, so a fresh frame starts from idx 0.

## Test plan
- Reset, then set only in_0 = 0x11 valid in cycle N, ready = 1 -> one beat in N+1: data 0x11, idx 0, last 1; then IDLE, busy_out 0.
- Full list {0x44,0x33,0x22,0x11} appears, ready = 1 -> four consecutive beats: idx 0..3, data 0x44, 0x33, 0x22, 0x11, last only on idx 3.
- Same list, ready low for 3 cycles on beat idx 1 -> data 0x33 and idx 1 held stable with valid high; stream resumes exactly once ready rises.
- Two list changes during a stalled frame, CNT_W = 2 -> overrun_cnt_out = 1; the next frame carries the latest list and starts the cycle after the last handshake. Repeat until overrun_cnt_out saturates at 3.
- enable_in = 0 while the list changes -> no beats, busy_out 0. Raise enable_in -> frame with the current list, first beat the next cycle.
- reset_n_in pulsed low during beat idx 2 with the list unchanged -> m_valid_out 0 immediately. After release -> a new frame from idx 0 with the full list.
